clk_adc_cfg_sequencer: RTL and testbench
========================================

// Module: clk_adc_cfg_sequencer
// PURPOSE
//  Power-up/recovery sequencer for board clocking. Drives the CDCE62005 SPI configurator
//  enable and waits for its active-low finish flag, then waits for a stable PLL lock.
//  Next it resets and configures the ADC, and only then raises sys_ready.
//  Sits between top-level reset/control and the clock/ADC config blocks.
//  Retries on timeouts; re-sequences on lock loss.
// PARAMETERS
//  RST_CYC       16       cycles cdce_en / adc_rst_n held low before each config
//  CFG_TIMEOUT   100000   max cycles waiting for cdce_cfg_done_n low or adc_cfg_done high
//  LOCK_STABLE   1024     consecutive synced pll_lock=1 cycles required
//  LOCK_TIMEOUT  1000000  max cycles in LOCK_WAIT
//  LOSS_CYC      8        consecutive synced pll_lock=0 cycles in READY = lock lost
//  MAX_RETRY     3        retries after first attempt before ERROR (retry_cnt width 4)
// PORTS
//  clk              in   1  system clock
//  rst_n            in   1  asynchronous active-low reset
//  start            in   1  start/restart request, rising-edge detected internally
//  cdce_cfg_done_n  in   1  CDCE configurator finish, active low
//  pll_lock         in   1  CDCE PLL lock, asynchronous, 2-flop synchronised
//  adc_cfg_done     in   1  ADC configurator done, level
//  cdce_en          out  1  enable to CDCE configurator (0 = held in its reset)
//  adc_rst_n        out  1  ADC/ADC-configurator reset, active low
//  adc_cfg_start    out  1  one-cycle pulse starting ADC configuration
//  sys_ready        out  1  clocks locked and ADC configured
//  cfg_error        out  1  retries exhausted, sticky until next start edge
//  lock_lost        out  1  sticky: lock dropped while READY; cleared on start edge
//  retry_cnt        out  4  retries used in current sequence
//  state_dbg        out  3  current state encoding
// BEHAVIOUR
//  Reset: all outputs 0 (cdce_en=0, adc_rst_n=0, adc_cfg_start=0, sys_ready=0, cfg_error=0,
//   lock_lost=0, retry_cnt=0), state IDLE, timers 0, sync flops 0. All outputs registered.
//  start_edge = start & ~start_q. Timer: 32-bit, cleared on every state change.
//  States (state_dbg): IDLE=0 CDCE_RST=1 CDCE_CFG=2 LOCK_WAIT=3 ADC_RST=4 ADC_CFG=5 READY=6 ERROR=7.
//  IDLE: on start_edge -> CDCE_RST; retry_cnt<=0; cfg_error<=0; lock_lost<=0.
//  CDCE_RST: cdce_en=0, adc_rst_n=0, sys_ready=0 for RST_CYC cycles -> CDCE_CFG.
//  CDCE_CFG: cdce_en=1. If cdce_cfg_done_n=0 -> LOCK_WAIT.
//   Else if timer reaches CFG_TIMEOUT-1 -> FAIL.
//  LOCK_WAIT: cdce_en stays 1. Stable counter increments while synced lock=1 and clears on 0.
//   If it reaches LOCK_STABLE -> ADC_RST. Else if timer reaches LOCK_TIMEOUT-1 -> FAIL.
//   When stable and timeout land on the same cycle, stable wins.
//  ADC_RST: adc_rst_n=0 for RST_CYC cycles, then adc_rst_n<=1 and adc_cfg_start<=1
//   for exactly one cycle -> ADC_CFG.
//  ADC_CFG: if adc_cfg_done=1 -> READY. Else if timer reaches CFG_TIMEOUT-1 -> FAIL.
//   Done wins over timeout. adc_cfg_done already high on entry is accepted on the first ADC_CFG cycle.
//  READY: sys_ready=1. LOSS_CYC consecutive synced lock=0 -> lock_lost<=1, sys_ready<=0,
//   retry_cnt<=0 -> CDCE_RST. Shorter glitches are ignored.
//  FAIL (transition, not a state): if retry_cnt<MAX_RETRY, retry_cnt+1 and -> CDCE_RST.
//   Else -> ERROR.
//  ERROR: cfg_error=1, cdce_en=0, adc_rst_n=0, sys_ready=0.
//  start_edge in any state other than IDLE restarts at CDCE_RST with retry_cnt, cfg_error
//   and lock_lost cleared; this includes mid-sequence restart.
//  start_edge takes priority over every other transition in the same cycle.
//  Asserting rst_n low mid-sequence returns everything to reset values immediately; no SPI
//   completion is awaited.
// TESTING (bench params: RST_CYC=4 CFG_TIMEOUT=50 LOCK_STABLE=8 LOCK_TIMEOUT=40
//  LOSS_CYC=3 MAX_RETRY=2)
//  Nominal: start pulse, done_n low 10 cyc after cdce_en, lock high -> adc_cfg_start single
//   pulse; adc_cfg_done 5 cyc later -> sys_ready=1, retry_cnt=0, state_dbg=6.
//  Lock timeout: pll_lock never high -> 3 LOCK_WAIT attempts, retry_cnt=2, then cfg_error=1,
//   state_dbg=7, cdce_en=0.
//  Lock chatter: lock high 7 cyc, low 1, high 8 -> leaves LOCK_WAIT only after the 8-cycle run.
//  Lock loss: in READY drop lock 2 cyc -> no change; drop 3 cyc -> lock_lost=1, sys_ready=0,
//   state_dbg=1.
//  ADC timeout then success: withhold adc_cfg_done first pass -> retry_cnt=1, full resequence;
//   second pass gives sys_ready=1.
//  Restart/reset: start edge in ADC_CFG -> state_dbg=1, counters cleared; rst_n low in
//   READY -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/clk_adc_cfg_sequencer.sv
// clk_adc_cfg_sequencer
//   Power-up / recovery sequencer for board clocking. Releases the CDCE62005
//   SPI configurator, waits for its active-low finish flag, waits for a stable
//   PLL lock, then resets and configures the ADC before raising sys_ready.
//   Configuration and lock timeouts are retried up to MAX_RETRY times before
//   parking in ERROR. Loss of lock while READY re-runs the whole sequence.
//
// Ports
//   clk, rst_n       system clock, asynchronous active-low reset
//   start            start/restart request (rising edge used)
//   cdce_cfg_done_n  CDCE configurator finished (active low)
//   pll_lock         CDCE PLL lock, asynchronous (2-flop synchronised here)
//   adc_cfg_done     ADC configurator done (level)
//   cdce_en          CDCE configurator enable (0 holds it in reset)
//   adc_rst_n        ADC / ADC-configurator reset (active low)
//   adc_cfg_start    one-cycle pulse starting ADC configuration
//   sys_ready        clocks locked and ADC configured
//   cfg_error        retries exhausted (sticky until a start edge)
//   lock_lost        lock dropped while ready (sticky until a start edge)
//   retry_cnt        retries used in the current sequence
//   state_dbg        current state encoding
module clk_adc_cfg_sequencer #(
  parameter int unsigned RST_CYC      = 16,
  parameter int unsigned CFG_TIMEOUT  = 100000,
  parameter int unsigned LOCK_STABLE  = 1024,
  parameter int unsigned LOCK_TIMEOUT = 1000000,
  parameter int unsigned LOSS_CYC     = 8,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cdce_cfg_done_n,
  input  logic       pll_lock,
  input  logic       adc_cfg_done,
  output logic       cdce_en,
  output logic       adc_rst_n,
  output logic       adc_cfg_start,
  output logic       sys_ready,
  output logic       cfg_error,
  output logic       lock_lost,
  output logic [3:0] retry_cnt,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CDCE_RST  = 3'd1,
    CDCE_CFG  = 3'd2,
    LOCK_WAIT = 3'd3,
    ADC_RST   = 3'd4,
    ADC_CFG   = 3'd5,
    READY     = 3'd6,
    ERROR     = 3'd7
  } state_t;

  localparam logic [31:0] RST_LAST    = 32'(RST_CYC - 1);
  localparam logic [31:0] CFG_LAST    = 32'(CFG_TIMEOUT - 1);
  localparam logic [31:0] LOCK_LAST   = 32'(LOCK_TIMEOUT - 1);
  localparam logic [31:0] STABLE_NEED = 32'(LOCK_STABLE);
  localparam logic [31:0] LOSS_NEED   = 32'(LOSS_CYC);
  localparam logic [3:0]  RETRY_MAX   = 4'(MAX_RETRY);

  state_t      state, state_n;
  logic [31:0] timer, timer_n;
  logic [31:0] stable_cnt, stable_n, stable_inc;
  logic [31:0] loss_cnt, loss_n, loss_inc;
  logic        start_q, lock_s1, lock_s2;
  logic        start_edge, fail, leave;
  logic [3:0]  retry_n;
  logic        lock_lost_n;
  logic        cdce_en_n, adc_rst_n_n, adc_cfg_start_n, sys_ready_n, cfg_error_n;

  assign start_edge = start & ~start_q;
  assign state_dbg  = state;

  always_comb begin
    state_n     = state;
    retry_n     = retry_cnt;
    lock_lost_n = lock_lost;
    fail        = 1'b0;
    stable_inc  = lock_s2 ? stable_cnt + 32'd1 : '0;
    loss_inc    = lock_s2 ? '0 : loss_cnt + 32'd1;

    unique case (state)
      IDLE, ERROR: ;
      CDCE_RST:  if (timer == RST_LAST) state_n = CDCE_CFG;
      CDCE_CFG:  if (!cdce_cfg_done_n)         state_n = LOCK_WAIT;
                 else if (timer == CFG_LAST)   fail    = 1'b1;
      LOCK_WAIT: if (stable_inc == STABLE_NEED) state_n = ADC_RST;
                 else if (timer == LOCK_LAST)   fail    = 1'b1;
      ADC_RST:   if (timer == RST_LAST) state_n = ADC_CFG;
      ADC_CFG:   if (adc_cfg_done)             state_n = READY;
                 else if (timer == CFG_LAST)   fail    = 1'b1;
      READY:     if (loss_inc == LOSS_NEED) begin
                   state_n     = CDCE_RST;
                   lock_lost_n = 1'b1;
                   retry_n     = '0;
                 end
    endcase

    if (fail) begin
      if (retry_cnt < RETRY_MAX) begin
        retry_n = retry_cnt + 4'd1;
        state_n = CDCE_RST;
      end else begin
        state_n = ERROR;
      end
    end

    if (start_edge) begin
      state_n     = CDCE_RST;
      retry_n     = '0;
      lock_lost_n = 1'b0;
    end

    // A restart from CDCE_RST keeps the same state but must still rewind the
    // timers, so "leave" covers both a state change and any start edge.
    leave    = start_edge || (state_n != state);
    timer_n  = leave ? '0 : timer + 32'd1;
    stable_n = leave ? '0 : stable_inc;
    loss_n   = leave ? '0 : loss_inc;

    // Outputs are registered from the next state so they line up with it.
    cdce_en_n       = state_n inside {CDCE_CFG, LOCK_WAIT, ADC_RST, ADC_CFG, READY};
    adc_rst_n_n     = state_n inside {ADC_CFG, READY};
    adc_cfg_start_n = (state == ADC_RST) && (state_n == ADC_CFG);
    sys_ready_n     = (state_n == READY);
    cfg_error_n     = (state_n == ERROR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      timer         <= '0;
      stable_cnt    <= '0;
      loss_cnt      <= '0;
      start_q       <= 1'b0;
      lock_s1       <= 1'b0;
      lock_s2       <= 1'b0;
      cdce_en       <= 1'b0;
      adc_rst_n     <= 1'b0;
      adc_cfg_start <= 1'b0;
      sys_ready     <= 1'b0;
      cfg_error     <= 1'b0;
      lock_lost     <= 1'b0;
      retry_cnt     <= '0;
    end else begin
      state         <= state_n;
      timer         <= timer_n;
      stable_cnt    <= stable_n;
      loss_cnt      <= loss_n;
      start_q       <= start;
      lock_s1       <= pll_lock;
      lock_s2       <= lock_s1;
      cdce_en       <= cdce_en_n;
      adc_rst_n     <= adc_rst_n_n;
      adc_cfg_start <= adc_cfg_start_n;
      sys_ready     <= sys_ready_n;
      cfg_error     <= cfg_error_n;
      lock_lost     <= lock_lost_n;
      retry_cnt     <= retry_n;
    end
  end

endmodule

// File: tb/tb_clk_adc_cfg_sequencer.sv
// Testbench for clk_adc_cfg_sequencer: directed scenarios plus a randomized
// phase, all checked every cycle against a duration-based behavioural model.
module tb_clk_adc_cfg_sequencer;

  localparam int RST_CYC      = 4;
  localparam int CFG_TIMEOUT  = 50;
  localparam int LOCK_STABLE  = 8;
  localparam int LOCK_TIMEOUT = 40;
  localparam int LOSS_CYC     = 3;
  localparam int MAX_RETRY    = 2;

  localparam int P_IDLE = 0, P_CRST = 1, P_CCFG = 2, P_LOCK = 3;
  localparam int P_ARST = 4, P_ACFG = 5, P_READY = 6, P_ERR = 7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       cdce_cfg_done_n = 1'b1;
  logic       pll_lock = 1'b0;
  logic       adc_cfg_done = 1'b0;
  logic       cdce_en, adc_rst_n, adc_cfg_start, sys_ready, cfg_error, lock_lost;
  logic [3:0] retry_cnt;
  logic [2:0] state_dbg;
  logic [12:0] dut_vec;

  int checks = 0;
  int errors = 0;

  clk_adc_cfg_sequencer #(
    .RST_CYC(RST_CYC), .CFG_TIMEOUT(CFG_TIMEOUT), .LOCK_STABLE(LOCK_STABLE),
    .LOCK_TIMEOUT(LOCK_TIMEOUT), .LOSS_CYC(LOSS_CYC), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cdce_cfg_done_n(cdce_cfg_done_n),
    .pll_lock(pll_lock), .adc_cfg_done(adc_cfg_done), .cdce_en(cdce_en),
    .adc_rst_n(adc_rst_n), .adc_cfg_start(adc_cfg_start), .sys_ready(sys_ready),
    .cfg_error(cfg_error), .lock_lost(lock_lost), .retry_cnt(retry_cnt),
    .state_dbg(state_dbg)
  );

  assign dut_vec = {cdce_en, adc_rst_n, adc_cfg_start, sys_ready, cfg_error,
                    lock_lost, retry_cnt, state_dbg};

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  int m_phase, m_age, m_run, m_low, m_retry;
  bit m_lost, m_pulse, m_start_prev;
  bit sync_q[$];

  task automatic model_reset();
    m_phase = P_IDLE; m_age = 0; m_run = 0; m_low = 0; m_retry = 0;
    m_lost = 0; m_pulse = 0; m_start_prev = 0;
    sync_q.delete();
    sync_q.push_back(1'b0);
    sync_q.push_back(1'b0);
  endtask

  task automatic model_step();
    bit s, st, go, fl;
    int nxt;
    s = sync_q.pop_front();
    sync_q.push_back(pll_lock);
    st = start && !m_start_prev;
    m_start_prev = start;
    m_pulse = 0; go = 0; fl = 0; nxt = m_phase;
    if (st) begin
      go = 1; nxt = P_CRST; m_retry = 0; m_lost = 0;
    end else begin
      case (m_phase)
        P_CRST: if (m_age + 1 == RST_CYC) begin go = 1; nxt = P_CCFG; end
        P_CCFG: if (!cdce_cfg_done_n) begin go = 1; nxt = P_LOCK; end
                else if (m_age + 1 == CFG_TIMEOUT) fl = 1;
        P_LOCK: begin
          m_run = s ? m_run + 1 : 0;
          if (m_run == LOCK_STABLE) begin go = 1; nxt = P_ARST; end
          else if (m_age + 1 == LOCK_TIMEOUT) fl = 1;
        end
        P_ARST: if (m_age + 1 == RST_CYC) begin go = 1; nxt = P_ACFG; m_pulse = 1; end
        P_ACFG: if (adc_cfg_done) begin go = 1; nxt = P_READY; end
                else if (m_age + 1 == CFG_TIMEOUT) fl = 1;
        P_READY: begin
          m_low = s ? 0 : m_low + 1;
          if (m_low == LOSS_CYC) begin go = 1; nxt = P_CRST; m_lost = 1; m_retry = 0; end
        end
        default: ;
      endcase
    end
    if (fl) begin
      go = 1;
      if (m_retry < MAX_RETRY) begin m_retry++; nxt = P_CRST; end
      else nxt = P_ERR;
    end
    if (go) begin m_phase = nxt; m_age = 0; m_run = 0; m_low = 0; end
    else m_age++;
  endtask

  function automatic logic [12:0] model_vec();
    logic en, arn;
    en  = (m_phase >= P_CCFG) && (m_phase <= P_READY);
    arn = (m_phase == P_ACFG) || (m_phase == P_READY);
    return {en, arn, m_pulse, (m_phase == P_READY), (m_phase == P_ERR), m_lost,
            4'(m_retry), 3'(m_phase)};
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // ---------------- every-cycle compare ----------------
  bit chk_on = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) chk("cycle_outputs", 32'(dut_vec), 32'(model_vec()));
    end
  end

  // ---------------- observation counters ----------------
  int pulse_cnt = 0;
  int lw_entries = 0;
  logic [2:0] last_st = 3'd0;
  initial begin
    forever begin
      @(negedge clk);
      if (adc_cfg_start) pulse_cnt++;
      if (state_dbg == 3'd3 && last_st != 3'd3) lw_entries++;
      last_st = state_dbg;
    end
  end

  // ---------------- configurator responders ----------------
  int cdce_delay = 10;
  int adc_delay = 5;
  int adc_withhold = 0;
  bit adc_stuck = 0;
  initial begin
    int cc, ac;
    bit armed;
    cc = 0; ac = 0; armed = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!cdce_en) begin
        cc = 0;
        cdce_cfg_done_n = 1'b1;
      end else begin
        cc++;
        cdce_cfg_done_n = !(cdce_delay >= 0 && cc >= cdce_delay);
      end
      if (!adc_rst_n) begin
        armed = 0; ac = 0;
      end else if (adc_cfg_start) begin
        if (adc_withhold > 0) begin adc_withhold--; armed = 0; end
        else armed = 1;
        ac = 0;
      end else begin
        ac++;
      end
      adc_cfg_done = adc_stuck || (armed && adc_delay >= 0 && ac >= adc_delay);
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int r, input int budget,
                            input string name);
    int n;
    n = 0;
    while (!(state_dbg == s && (r < 0 || retry_cnt == 4'(r)))) begin
      if (n >= budget) begin
        checks++;
        errors++;
        $display("FAIL %s: timeout, state_dbg=%0d retry_cnt=%0d required state %0d",
                 name, state_dbg, retry_cnt, s);
        return;
      end
      cyc(1);
      n++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    bit lock_dead;
    cyc(3);
    chk_on = 1;
    chk("reset_outputs", 32'(dut_vec), 32'd0);
    rst_n = 1'b1;
    cyc(3);
    chk("idle_without_start", 32'(state_dbg), 32'd0);

    // Nominal bring-up
    pll_lock = 1'b1; pulse_cnt = 0;
    pulse_start();
    chk("after_start_state", 32'(state_dbg), 32'd1);
    wait_state(3'd6, -1, 300, "nominal_ready");
    chk("nominal_sys_ready", 32'(sys_ready), 32'd1);
    chk("nominal_retry", 32'(retry_cnt), 32'd0);
    chk("nominal_state", 32'(state_dbg), 32'd6);
    chk("nominal_start_pulses", 32'(pulse_cnt), 32'd1);

    // Lock glitch then real loss; ADC withheld twice afterwards
    adc_withhold = 2;
    pll_lock = 1'b0; cyc(2); pll_lock = 1'b1; cyc(5);
    chk("glitch_ready", 32'(sys_ready), 32'd1);
    chk("glitch_state", 32'(state_dbg), 32'd6);
    chk("glitch_lock_lost", 32'(lock_lost), 32'd0);
    pll_lock = 1'b0; cyc(3); pll_lock = 1'b1; cyc(3);
    chk("loss_state", 32'(state_dbg), 32'd1);
    chk("loss_sys_ready", 32'(sys_ready), 32'd0);
    chk("loss_lock_lost", 32'(lock_lost), 32'd1);

    // Restart in ADC_CFG of the second pass
    wait_state(3'd5, 1, 400, "second_adc_pass");
    chk("lock_lost_sticky", 32'(lock_lost), 32'd1);
    pulse_start();
    chk("restart_state", 32'(state_dbg), 32'd1);
    chk("restart_retry", 32'(retry_cnt), 32'd0);
    chk("restart_lock_lost", 32'(lock_lost), 32'd0);
    wait_state(3'd6, -1, 300, "after_restart_ready");
    chk("after_restart_retry", 32'(retry_cnt), 32'd0);

    // ADC timeout then success
    adc_withhold = 1;
    pulse_start();
    wait_state(3'd6, -1, 400, "adc_retry_ready");
    chk("adc_retry_count", 32'(retry_cnt), 32'd1);
    chk("adc_retry_sys_ready", 32'(sys_ready), 32'd1);

    // Lock never arrives
    pll_lock = 1'b0; lw_entries = 0;
    pulse_start();
    wait_state(3'd7, -1, 600, "lock_timeout_error");
    chk("lock_to_retry", 32'(retry_cnt), 32'd2);
    chk("lock_to_cfg_error", 32'(cfg_error), 32'd1);
    chk("lock_to_cdce_en", 32'(cdce_en), 32'd0);
    chk("lock_to_sys_ready", 32'(sys_ready), 32'd0);
    chk("lock_to_attempts", 32'(lw_entries), 32'd3);

    // Lock chatter: 7 high, 1 low, 8 high
    pulse_start();
    chk("error_cleared", 32'(cfg_error), 32'd0);
    wait_state(3'd3, -1, 100, "chatter_lock_wait");
    pll_lock = 1'b1; cyc(7);
    pll_lock = 1'b0; cyc(1);
    pll_lock = 1'b1; cyc(9);
    chk("chatter_still_waiting", 32'(state_dbg), 32'd3);
    cyc(1);
    chk("chatter_released", 32'(state_dbg), 32'd4);
    wait_state(3'd6, -1, 200, "chatter_ready");

    // Asynchronous reset mid-cycle while READY
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 32'(dut_vec), 32'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(3);
    chk("post_reset_idle", 32'(dut_vec), 32'd0);

    // Randomized phase
    for (int blk = 0; blk < 25; blk++) begin
      cdce_delay = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 15));
      adc_delay  = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 12));
      adc_stuck  = ($urandom_range(0, 7) == 0);
      lock_dead  = ($urandom_range(0, 5) == 0);
      adc_withhold = 0;
      for (int c = 0; c < 200; c++) begin
        if (lock_dead) pll_lock = 1'b0;
        else if (pll_lock) pll_lock = ($urandom_range(0, 24) != 0);
        else pll_lock = ($urandom_range(0, 2) == 0);
        start = ($urandom_range(0, 249) == 0) ? 1'b1 : (start && ($urandom_range(0, 1) == 1));
        rst_n = ($urandom_range(0, 1499) == 0) ? 1'b0 : 1'b1;
        cyc(1);
      end
    end
    rst_n = 1'b1;
    start = 1'b0;
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
